microwave_timer_ctrl: RTL and testbench

Parametrised microwave controller core: one-hot keypad entry, BCD countdown, door/stop/clear interlocks, power-level duty cycling of the magnetron and per-digit 7-segment outputs.
Successor to the fixed 3-digit controller. Adds a configurable digit count and prescaler, a power-level mode, a two-press stop-to-clear sequence and a done pulse.
Sits between the front-panel inputs (keypad, buttons, door switch) and the display/magnetron drivers.

---
 rtl/microwave_pkg.sv | 10 +
 rtl/bcd_to_seg7.sv | 9 +
 rtl/microwave_timer_ctrl.sv | 149 ++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg: shared states, keypad width, 7-segment table and power clamp
package microwave_pkg;
  typedef enum logic [1:0] {IDLE, COOK, PAUSE} state_t;
  localparam int KEY_W = 10;
  localparam logic [9:0][6:0] SEG7 = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  function automatic logic [3:0] clamp_power(input logic [3:0] p);
    return (p == 4'd0 || p > 4'd10) ? 4'd10 : p;
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: one BCD digit to active-high a..g segments
module bcd_to_seg7
  import microwave_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb seg = (bcd > 4'd9) ? 7'h00 : SEG7[bcd];
endmodule

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: keypad entry, BCD countdown, interlocks and power duty cycling
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000,
  parameter int PWR_WINDOW = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [KEY_W-1:0]        keypad,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    clearn,
  input  logic                    door_closed,
  input  logic [3:0]              power,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    mag_on,
  output logic                    cooking,
  output logic                    done
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int WW = PWR_WINDOW > 1 ? $clog2(PWR_WINDOW) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WIN_MAX = WW'(PWR_WINDOW - 1);
  state_t state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d, dig_dec;
  logic [PW-1:0] pre_q, pre_d;
  logic [WW-1:0] win_q, win_d;
  logic [3:0] pwr_q, pwr_d;
  logic mag_q, mag_d, done_q, done_d;
  logic [KEY_W-1:0] keypad_q, keypad_prev_q;
  logic startn_q, startn_prev_q, stopn_q, stopn_prev_q, clearn_q, clearn_prev_q, door_q;
  logic [3:0] power_q;
  logic start_hit, stop_hit, clear_hit, key_hit, borrow;
  logic [3:0] key_val;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      dig_q         <= '0;
      pre_q         <= '0;
      win_q         <= '0;
      pwr_q         <= '0;
      mag_q         <= 1'b0;
      done_q        <= 1'b0;
      keypad_q      <= '0;
      keypad_prev_q <= '0;
      startn_q      <= 1'b1;
      startn_prev_q <= 1'b1;
      stopn_q       <= 1'b1;
      stopn_prev_q  <= 1'b1;
      clearn_q      <= 1'b1;
      clearn_prev_q <= 1'b1;
      door_q        <= 1'b0;
      power_q       <= '0;
    end else begin
      state_q       <= state_d;
      dig_q         <= dig_d;
      pre_q         <= pre_d;
      win_q         <= win_d;
      pwr_q         <= pwr_d;
      mag_q         <= mag_d;
      done_q        <= done_d;
      keypad_q      <= keypad;
      keypad_prev_q <= keypad_q;
      startn_q      <= startn;
      startn_prev_q <= startn_q;
      stopn_q       <= stopn;
      stopn_prev_q  <= stopn_q;
      clearn_q      <= clearn;
      clearn_prev_q <= clearn_q;
      door_q        <= door_closed;
      power_q       <= power;
    end
  end
  always_comb begin
    start_hit = startn_prev_q & ~startn_q;
    stop_hit  = stopn_prev_q & ~stopn_q;
    clear_hit = clearn_prev_q & ~clearn_q;
    key_hit   = (keypad_prev_q == '0) && $onehot(keypad_q);
    key_val   = '0;
    for (int i = 0; i < KEY_W; i++)
      if (keypad_q[i]) key_val = 4'(i);
  end
  // Borrow ripples up from the ones digit; sec tens reloads to 5, all others to 9
  always_comb begin
    dig_dec = dig_q;
    borrow  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        dig_dec[i] = (dig_q[i] != 4'd0) ? dig_q[i] - 4'd1 : ((i == 1) ? 4'd5 : 4'd9);
        borrow     = (dig_q[i] == 4'd0);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    pre_d   = pre_q;
    win_d   = win_q;
    pwr_d   = pwr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_hit || stop_hit) dig_d = '0;
        else if (start_hit) begin
          if (door_q && dig_q != '0) begin
            state_d = COOK;
            pre_d   = '0;
            win_d   = '0;
            pwr_d   = clamp_power(power_q);
          end
        end else if (key_hit) dig_d = {dig_q[NUM_DIGITS-2:0], key_val};
      end
      COOK: begin
        if (clear_hit) begin
          state_d = IDLE;
          dig_d   = '0;
        end else if (stop_hit || !door_q) state_d = PAUSE;
        else if (pre_q == PRE_MAX) begin
          pre_d = '0;
          dig_d = dig_dec;
          win_d = (win_q == WIN_MAX) ? '0 : win_q + WW'(1);
          if (dig_dec == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else pre_d = pre_q + PW'(1);
      end
      PAUSE: begin
        if (clear_hit || stop_hit) begin
          state_d = IDLE;
          dig_d   = '0;
        end else if (start_hit && door_q) state_d = COOK;
      end
      default: state_d = IDLE;
    endcase
    // Built from next-state values so the magnetron drops on the same edge COOK is left
    mag_d = (state_d == COOK) && door_q && (32'(win_d) < 32'(pwr_d));
  end
  assign digits_bcd = dig_q;
  assign cooking    = (state_q == COOK);
  assign mag_on     = mag_q;
  assign done       = done_q;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_seg
    bcd_to_seg7 u_seg (.bcd(dig_q[i]), .seg(seg[7*i +: 7]));
  end
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb_microwave_timer_ctrl: directed plus random stimulus against a seconds-level reference model
module tb_microwave_timer_ctrl;
  localparam int ND = 4, TD = 4, PWIN = 10;
  localparam int S_IDLE = 0, S_COOK = 1, S_PAUSE = 2;
  logic clock = 1'b0, reset = 1'b1;
  logic [9:0] keypad = '0;
  logic startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b0;
  logic [3:0] power = '0;
  logic [4*ND-1:0] digits_bcd;
  logic [7*ND-1:0] seg;
  logic mag_on, cooking, done;
  int checks = 0, errors = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int m_st, m_n, m_pre, m_win, m_pwr, pr;
  bit m_mag, m_done, sr, sp, tr, tp, cr, cp, dr;
  bit [9:0] kr, kp;

  microwave_timer_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .PWR_WINDOW(PWIN)) dut (
    .clock(clock), .reset(reset), .keypad(keypad), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed), .power(power), .digits_bcd(digits_bcd),
    .seg(seg), .mag_on(mag_on), .cooking(cooking), .done(done));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // time is kept as the decimal number shown on the display (MMSS, seconds may be raw 60-99)
  function automatic int dec_time(input int n);
    return (n % 100 > 0) ? n - 1 : (n / 100 - 1) * 100 + 59;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [27:0] exp_seg(input int n);
    logic [15:0] b = to_bcd(n);
    logic [27:0] s = '0;
    for (int i = 0; i < ND; i++) s[7*i +: 7] = seg_tab[b[4*i +: 4]];
    return s;
  endfunction

  task automatic model_step();
    bit kh, sh, th, ch;
    int kd;
    if (reset) begin
      m_st = S_IDLE; m_n = 0; m_pre = 0; m_win = 0; m_pwr = 0; m_mag = 0; m_done = 0;
      kr = '0; kp = '0; sr = 1; sp = 1; tr = 1; tp = 1; cr = 1; cp = 1; dr = 0; pr = 0;
      return;
    end
    kh = (kp == 0) && ($countones(kr) == 1);
    kd = 0;
    for (int i = 0; i < 10; i++) if (kr[i]) kd = i;
    sh = sp && !sr; th = tp && !tr; ch = cp && !cr;
    m_done = 0;
    if (m_st == S_IDLE) begin
      if (ch || th) m_n = 0;
      else if (sh) begin
        if (dr && m_n != 0) begin
          m_st = S_COOK; m_pre = 0; m_win = 0;
          m_pwr = (pr == 0 || pr > 10) ? 10 : pr;
        end
      end else if (kh) m_n = (m_n * 10 + kd) % 10000;
    end else if (m_st == S_COOK) begin
      if (ch) begin m_st = S_IDLE; m_n = 0; end
      else if (th || !dr) m_st = S_PAUSE;
      else if (m_pre == TD - 1) begin
        m_pre = 0; m_n = dec_time(m_n); m_win = (m_win + 1) % PWIN;
        if (m_n == 0) begin m_st = S_IDLE; m_done = 1; end
      end else m_pre++;
    end else begin
      if (ch || th) begin m_st = S_IDLE; m_n = 0; end
      else if (sh && dr) m_st = S_COOK;
    end
    m_mag = (m_st == S_COOK) && dr && (m_win < m_pwr);
    kp = kr; kr = keypad; sp = sr; sr = startn; tp = tr; tr = stopn; cp = cr; cr = clearn;
    dr = door_closed; pr = int'(power);
  endtask

  always @(posedge clock) begin
    model_step();
    #1;
    check("digits", digits_bcd, to_bcd(m_n));
    check("seg", seg, exp_seg(m_n));
    check("cooking", cooking, m_st == S_COOK);
    check("mag_on", mag_on, m_mag);
    check("done", done, m_done);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic key(input int k);
    keypad = 10'(1 << k); tick(2); keypad = '0; tick(2);
  endtask

  task automatic btn(input int b);
    if (b == 0) startn = 0; else if (b == 1) stopn = 0; else clearn = 0;
    tick(2);
    startn = 1; stopn = 1; clearn = 1;
    tick(2);
  endtask

  task automatic wait_time(input logic [15:0] v, input int lim, input string tag);
    int n = 0;
    while (digits_bcd !== v && n < lim) begin tick(1); n++; end
    check(tag, digits_bcd, v);
  endtask

  task automatic cook_profile(input string tag, input int cyc_exp, input int hi_exp);
    int n = 0, hi = 0;
    startn = 0;
    while (!cooking && n < 10) begin tick(1); n++; end
    startn = 1;
    check({tag, "_start"}, cooking, 1);
    n = 0;
    while (!done && n < 400) begin if (mag_on) hi++; n++; tick(1); end
    check({tag, "_cycles"}, n, cyc_exp);
    check({tag, "_duty"}, hi, hi_exp);
  endtask

  initial begin
    int n;
    tick(3); reset = 0; tick(1);
    check("rst_digits", digits_bcd, 0);
    check("rst_cooking", cooking, 0);
    check("rst_mag", mag_on, 0);
    // door-open start, then a full cook from 0359
    key(3); key(5); key(9); btn(0);
    check("t1_open_start", cooking, 0);
    check("t1_entry", digits_bcd, 16'h0359);
    door_closed = 1; tick(2);
    startn = 0; n = 0;
    while (!cooking && n < 10) begin tick(1); n++; end
    startn = 1;
    check("t1_cook", cooking, 1);
    check("t1_mag", mag_on, 1);
    n = 0;
    while (digits_bcd == 16'h0359 && n < 20) begin tick(1); n++; end
    check("t1_first_dec_lat", n, TD);
    check("t1_0358", digits_bcd, 16'h0358);
    wait_time(16'h0300, 300, "t1_0300");
    wait_time(16'h0259, 8, "t1_0259");
    n = 0;
    while (!done && n < 800) begin tick(1); n++; end
    check("t1_done", done, 1);
    check("t1_done_mag", mag_on, 0);
    check("t1_done_idle", cooking, 0);
    check("t1_zero", digits_bcd, 0);
    tick(1);
    check("t1_done_pulse", done, 0);
    // door interlock
    key(2); key(4); key(5); btn(0);
    wait_time(16'h0242, 20, "t2_0242");
    door_closed = 0; tick(2);
    check("t2_mag_off", mag_on, 0);
    check("t2_pause", cooking, 0);
    tick(10);
    check("t2_frozen", digits_bcd, 16'h0242);
    btn(0);
    check("t2_open_start", cooking, 0);
    door_closed = 1; tick(2); btn(0);
    check("t2_resume", cooking, 1);
    wait_time(16'h0241, 10, "t2_0241");
    // stop, resume, double-stop clear
    btn(2);
    key(2); key(4); key(5); btn(0);
    wait_time(16'h0242, 20, "t3_0242");
    btn(1);
    check("t3_pause", cooking, 0);
    tick(8);
    check("t3_held", digits_bcd, 16'h0242);
    btn(0);
    check("t3_resume", cooking, 1);
    btn(1); btn(1);
    check("t3_cleared", digits_bcd, 0);
    check("t3_idle", cooking, 0);
    btn(0);
    check("t3_zero_start", cooking, 0);
    // clear, and clear beating start
    key(2); key(4); key(5); btn(0); tick(3); btn(2);
    check("t4_clear", digits_bcd, 0);
    check("t4_mag", mag_on, 0);
    key(1);
    clearn = 0; startn = 0; tick(2); clearn = 1; startn = 1; tick(2);
    check("t4_clear_wins", cooking, 0);
    check("t4_clear_digits", digits_bcd, 0);
    // power duty cycling
    power = 3; key(2); key(0);
    cook_profile("t5_p3", 20 * TD, 6 * TD);
    power = 0; key(1); key(0);
    cook_profile("t5_p0", 10 * TD, 10 * TD);
    // entry edge cases and raw seconds
    key(1); key(2); key(3); key(4); key(5);
    check("t6_shift", digits_bcd, 16'h2345);
    btn(2); key(1); key(2);
    keypad = 10'b0000000110; tick(2); keypad = '0; tick(2);
    check("t6_multihot", digits_bcd, 16'h0012);
    btn(2); key(9); key(5); btn(0);
    wait_time(16'h0094, 10, "t6_0094");
    wait_time(16'h0090, 30, "t6_0090");
    wait_time(16'h0089, 8, "t6_0089");
    btn(2);
    key(9); key(9); key(9); key(9);
    check("t6_max", digits_bcd, 16'h9999);
    btn(0);
    wait_time(16'h9859, 420, "t6_9859");
    btn(2);
    // random stimulus, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      int r = $urandom_range(0, 9);
      reset = ($urandom_range(0, 199) == 0);
      keypad = (r < 6) ? '0 : (r < 9) ? 10'(1 << $urandom_range(0, 9)) : 10'($urandom);
      startn = ($urandom_range(0, 7) != 0);
      stopn = ($urandom_range(0, 39) != 0);
      clearn = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 49) == 0) door_closed = ~door_closed;
      power = 4'($urandom_range(0, 15));
      tick(1);
    end
    reset = 0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
